// File: rtl/sram_pkg.sv
// Shared SRAM geometry constants and the write-mask width helper.
// Used by the request adapter, its interface and the SRAM macro wrapper.
package sram_pkg;

    localparam int SRAM_ADDR_WIDTH = 10;
    localparam int SRAM_DATA_WIDTH = 128;
    localparam int SRAM_MASK_UNIT  = 8;

    // Number of write-mask lanes needed to cover a data word (rounded up).
    function automatic int mask_width(input int data_width, input int mask_unit);
        return (data_width + mask_unit - 1) / mask_unit;
    endfunction

endpackage

// File: rtl/sram_req_adapter_if.sv
// Request / read-response channel bundle between a client and sram_req_adapter.
// master: the requesting client.  slave: the adapter.
interface sram_req_adapter_if import sram_pkg::*; #(
    parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int MASK_WIDTH = mask_width(SRAM_DATA_WIDTH, SRAM_MASK_UNIT)
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [MASK_WIDTH-1:0] req_mask;
    logic [DATA_WIDTH-1:0] req_data;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;

    modport master (
        output req_valid, req_write, req_addr, req_mask, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_mask, req_data, resp_ready,
        output req_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/sram_req_adapter_resp_fifo.sv
// sram_resp_fifo: small circular response buffer (DEPTH x WIDTH).
// Pointers wrap modulo DEPTH so non power-of-two depths work.
// Storage is deliberately left unreset; only pointers and occupancy are cleared.
module sram_resp_fifo import sram_pkg::*; #(
    parameter int DEPTH = 2,
    parameter int WIDTH = SRAM_DATA_WIDTH
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head_data,
    output logic [$clog2(DEPTH + 1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Advance a pointer, wrapping at the last entry.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    // Write the pushed word into the slot under the write pointer.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together keeps count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

endmodule

// File: rtl/sram_req_adapter.sv
// sram_req_adapter: turns a valid/ready request channel into single-port SRAM
// accesses and returns read data over a valid/ready response channel.
// Requests are only accepted while a response slot is guaranteed (credit =
// FIFO occupancy + the read currently coming out of the SRAM), so the SRAM
// never needs to stall. With an empty FIFO the SRAM output bypasses straight
// to the response channel, giving one-cycle read latency.
// Optional feature macro: SRAM_REQ_ADAPTER_WRITE_ACK_EN -- writes also return
// one all-zero response, ordered with reads.
module sram_req_adapter import sram_pkg::*; #(
    parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int MASK_UNIT  = SRAM_MASK_UNIT,
    parameter int MASK_WIDTH = mask_width(DATA_WIDTH, MASK_UNIT),
    parameter int RESP_DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    sram_req_adapter_if.slave     bus,
    output logic                  sram_enable,
    output logic                  sram_write,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [MASK_WIDTH-1:0] sram_mask,
    output logic [DATA_WIDTH-1:0] sram_dataIn,
    input  logic [DATA_WIDTH-1:0] sram_dataOut
);

    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    logic                  fire_s;
    logic                  launch_s;
    logic                  inflight_r;
    logic [DATA_WIDTH-1:0] resp_word_s;
    logic [CNT_W-1:0]      count_s;
    logic [DATA_WIDTH-1:0] head_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  resp_valid_s;
    logic [DATA_WIDTH-1:0] resp_data_s;

    // Credit check depends only on state, never on the incoming request.
    assign bus.req_ready = ({1'b0, count_s} + {{CNT_W{1'b0}}, inflight_r})
                           < (CNT_W + 1)'(RESP_DEPTH);
    assign fire_s        = bus.req_valid && bus.req_ready;

    assign sram_enable = fire_s;
    assign sram_write  = bus.req_write;
    assign sram_addr   = bus.req_addr;
    assign sram_mask   = bus.req_mask;
    assign sram_dataIn = bus.req_data;

`ifdef SRAM_REQ_ADAPTER_WRITE_ACK_EN
    logic ack_r;

    assign launch_s    = fire_s;
    assign resp_word_s = ack_r ? {DATA_WIDTH{1'b0}} : sram_dataOut;

    // Remember that the word leaving the SRAM this cycle is a write acknowledge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ack_r <= 1'b0;
        end else begin
            ack_r <= fire_s && bus.req_write;
        end
    end
`else
    assign launch_s    = fire_s && !bus.req_write;
    assign resp_word_s = sram_dataOut;
`endif

    // Flag the cycle in which the SRAM presents data for an accepted request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= launch_s;
        end
    end

    // Response steering: FIFO head first, else bypass the SRAM word.
    always_comb begin
        push_s       = 1'b0;
        pop_s        = 1'b0;
        resp_valid_s = 1'b0;
        resp_data_s  = {DATA_WIDTH{1'b0}};
        if (count_s != {CNT_W{1'b0}}) begin
            resp_valid_s = 1'b1;
            resp_data_s  = head_s;
            pop_s        = bus.resp_ready;
            push_s       = inflight_r;
        end else if (inflight_r) begin
            resp_valid_s = 1'b1;
            resp_data_s  = resp_word_s;
            push_s       = !bus.resp_ready;
        end else begin
            resp_valid_s = 1'b0;
        end
    end

    assign bus.resp_valid = resp_valid_s;
    assign bus.resp_data  = resp_data_s;

    sram_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_resp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push_s),
        .push_data (resp_word_s),
        .pop       (pop_s),
        .head_data (head_s),
        .count     (count_s)
    );

endmodule

// File: tb/tb_sram_req_adapter.sv
// Self-checking bench for sram_req_adapter with a behavioural SRAM and a
// transaction-level reference model (queue of outstanding response words).
module tb_sram_req_adapter;
    import sram_pkg::*;

    localparam int AW    = SRAM_ADDR_WIDTH;
    localparam int DW    = SRAM_DATA_WIDTH;
    localparam int MU    = SRAM_MASK_UNIT;
    localparam int MW    = mask_width(DW, MU);
    localparam int DEPTH = 3;
`ifdef SRAM_REQ_ADAPTER_WRITE_ACK_EN
    localparam bit WACK = 1'b1;
`else
    localparam bit WACK = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    sram_req_adapter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) bus ();

    logic          sram_enable;
    logic          sram_write;
    logic [AW-1:0] sram_addr;
    logic [MW-1:0] sram_mask;
    logic [DW-1:0] sram_dataIn;
    logic [DW-1:0] sram_dataOut;

    sram_req_adapter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MASK_UNIT  (MU),
        .MASK_WIDTH (MW),
        .RESP_DEPTH (DEPTH)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus          (bus),
        .sram_enable  (sram_enable),
        .sram_write   (sram_write),
        .sram_addr    (sram_addr),
        .sram_mask    (sram_mask),
        .sram_dataIn  (sram_dataIn),
        .sram_dataOut (sram_dataOut)
    );

    // Behavioural SRAM: registered read, output held, lane-masked write.
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (sram_enable) begin
            if (sram_write) begin
                for (int i = 0; i < MW; i++) begin
                    if (sram_mask[i]) sram_mem[sram_addr][i*MU +: MU] <= sram_dataIn[i*MU +: MU];
                end
            end else begin
                sram_dataOut <= sram_mem[sram_addr];
            end
        end
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_q [$];

    int checks = 0;
    int failures = 0;
    int resp_cnt = 0;
    int en_cnt = 0;
    int ready_low = 0;
    logic [DW-1:0] last_resp = '0;

    function automatic logic [DW-1:0] init_word(input int i);
        return {4{32'hC0DE0000 | 32'(i)}};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model by one edge.
    initial begin
        logic exp_ready;
        logic exp_fire;
        forever begin
            @(negedge clock);
            if (!reset_n) exp_q.delete();
            exp_ready = (exp_q.size() < DEPTH);
            exp_fire  = bus.req_valid && exp_ready;
            chk("req_ready", DW'(bus.req_ready), DW'(exp_ready));
            chk("resp_valid", DW'(bus.resp_valid), DW'(exp_q.size() > 0));
            if (exp_q.size() > 0) chk("resp_data", bus.resp_data, exp_q[0]);
            chk("sram_enable", DW'(sram_enable), DW'(exp_fire));
            chk("sram_write", DW'(sram_write), DW'(bus.req_write));
            chk("sram_addr", DW'(sram_addr), DW'(bus.req_addr));
            chk("sram_mask", DW'(sram_mask), DW'(bus.req_mask));
            chk("sram_dataIn", sram_dataIn, bus.req_data);
            if (bus.resp_valid && bus.resp_ready) begin
                resp_cnt++;
                last_resp = bus.resp_data;
            end
            if (sram_enable) en_cnt++;
            if (!bus.req_ready) ready_low++;
            if (reset_n) begin
                if (exp_q.size() > 0 && bus.resp_ready) void'(exp_q.pop_front());
                if (exp_fire) begin
                    if (bus.req_write) begin
                        for (int i = 0; i < MW; i++) begin
                            if (bus.req_mask[i]) ref_mem[bus.req_addr][i*MU +: MU] = bus.req_data[i*MU +: MU];
                        end
                        if (WACK) exp_q.push_back({DW{1'b0}});
                    end else begin
                        exp_q.push_back(ref_mem[bus.req_addr]);
                    end
                end
            end
        end
    end

    // Present one request and hold it until accepted (bounded).
    task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [MW-1:0] m,
                          input logic [DW-1:0] d);
        int waited = 0;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_mask  = m;
        bus.req_data  = d;
        @(negedge clock);
        while (!bus.req_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (!bus.req_ready) begin
            checks++;
            failures++;
            $display("FAIL req_accept_timeout actual=not_accepted required=accepted at %0t", $time);
        end
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
    endtask

    // Wait (bounded) until the model has no outstanding responses.
    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
        @(posedge clock); #1;
    endtask

    initial begin
        int base;
        int en_base;
        int low_base;
        for (int i = 0; i < (1 << AW); i++) begin
            sram_mem[i] = init_word(i);
            ref_mem[i]  = init_word(i);
        end
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_mask   = '0;
        bus.req_data   = '0;
        bus.resp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_req_ready", DW'(bus.req_ready), DW'(1'b1));
        chk("rst_resp_valid", DW'(bus.resp_valid), DW'(1'b0));
        chk("rst_sram_enable", DW'(sram_enable), DW'(1'b0));
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Write then read back: response one cycle after the read fire
        do_req(1'b1, 10'h005, {MW{1'b1}}, {16{8'hA5}});
        do_req(1'b0, 10'h005, {MW{1'b0}}, {DW{1'b0}});
        @(negedge clock);
        chk("t030_resp_valid", DW'(bus.resp_valid), DW'(1'b1));
        chk("t030_resp_data", bus.resp_data, {16{8'hA5}});
        @(posedge clock); #1;
        wait_drain();

        // Back-to-back reads 0..7 with resp_ready held high
        base = resp_cnt;
        low_base = ready_low;
        for (int i = 0; i < 8; i++) do_req(1'b0, AW'(i), {MW{1'b0}}, {DW{1'b0}});
        wait_drain();
        chk("t031_resp_count", DW'(resp_cnt - base), DW'(8));
        chk("t031_ready_drops", DW'(ready_low - low_base), DW'(0));
        chk("t031_last_data", last_resp, init_word(7));

        // Backpressure: only DEPTH reads accepted, then drain in order
        bus.resp_ready = 1'b0;
        en_base = en_cnt;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.req_addr = AW'(16 + k);
            @(posedge clock); #1;
        end
        bus.req_valid = 1'b0;
        @(negedge clock);
        chk("t032_accepted", DW'(en_cnt - en_base), DW'(DEPTH));
        chk("t032_req_ready_low", DW'(bus.req_ready), DW'(1'b0));
        @(posedge clock); #1;
        base = resp_cnt;
        bus.resp_ready = 1'b1;
        wait_drain();
        chk("t032_drained", DW'(resp_cnt - base), DW'(DEPTH));
        chk("t032_last_data", last_resp, init_word(18));
        chk("t032_req_ready_back", DW'(bus.req_ready), DW'(1'b1));

        // Full write then lane-masked write, read back
        base = resp_cnt;
        do_req(1'b1, 10'h020, {MW{1'b1}}, {DW{1'b1}});
        do_req(1'b1, 10'h020, MW'(1), {DW{1'b0}});
        do_req(1'b0, 10'h020, {MW{1'b0}}, {DW{1'b0}});
        wait_drain();
        chk("t033_readback", last_resp, {{(DW-8){1'b1}}, 8'h00});
        chk("t033_resp_count", DW'(resp_cnt - base), DW'(WACK ? 3 : 1));

        // Reset with DEPTH-1 words buffered and one inflight
        bus.resp_ready = 1'b0;
        en_base = en_cnt;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            bus.req_addr = AW'(48 + k);
            @(posedge clock); #1;
        end
        chk("t034_setup_accepted", DW'(en_cnt - en_base), DW'(DEPTH));
        reset_n = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clock);
        chk("t034_resp_valid", DW'(bus.resp_valid), DW'(1'b0));
        chk("t034_req_ready", DW'(bus.req_ready), DW'(1'b1));
        @(posedge clock); #1;
        reset_n = 1'b1;
        bus.resp_ready = 1'b1;
        base = resp_cnt;
        repeat (5) begin
            @(posedge clock); #1;
        end
        chk("t034_no_stale", DW'(resp_cnt - base), DW'(0));

        // Still operational after reset
        do_req(1'b0, 10'h005, {MW{1'b0}}, {DW{1'b0}});
        wait_drain();
        chk("post_reset_read", last_resp, {16{8'hA5}});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound.
    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_req_adapter.md
SRAM_REQ_ADAPTER -- requirements
Module: sram_req_adapter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, SRAM word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 128, data word width.
REQ-003 SHALL have parameter MASK_UNIT, default 8, bits per write-mask lane.
REQ-004 SHALL have parameter MASK_WIDTH, default ceil(DATA_WIDTH/MASK_UNIT), write-mask width.
REQ-005 SHALL have parameter RESP_DEPTH, default 2, response FIFO entries (>=1).
REQ-006 Port: clock  in  1  sole clock; all state on its rising edge.
REQ-007 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-008 Ports: req_valid in 1, req_ready out 1, req_write in 1, req_addr in ADDR_WIDTH, req_mask in MASK_WIDTH, req_data in DATA_WIDTH; the request channel.
REQ-009 Ports: resp_valid out 1, resp_ready in 1, resp_data out DATA_WIDTH; the read-response channel.
REQ-010 Ports: sram_enable, sram_write out 1; sram_addr out ADDR_WIDTH; sram_mask out MASK_WIDTH; sram_dataIn out DATA_WIDTH; sram_dataOut in DATA_WIDTH; one SRAM rw port (1-cycle registered read, output held when not reading).

Function
REQ-011 Request accepted ("fire") SHALL be req_valid && req_ready in the same cycle.
REQ-012 sram_enable SHALL equal fire combinationally; sram_write/addr/mask/dataIn SHALL be pass-through of req_write/addr/mask/data.
REQ-013 A read fire SHALL set register inflight for exactly the next cycle, in which sram_dataOut holds the read data.
REQ-014 Credit rule: req_ready SHALL be 1 iff count + inflight < RESP_DEPTH, where count = FIFO occupancy; req_ready SHALL NOT depend on req_valid or req_write.
REQ-015 Bypass: when inflight && count==0, resp_valid SHALL be 1 and resp_data SHALL equal sram_dataOut; if resp_ready is also 1 the word SHALL NOT enter the FIFO.
REQ-016 Otherwise an inflight word SHALL be pushed into the FIFO at the end of its cycle; resp_valid = (count>0) || inflight; resp_data = FIFO head when count>0.
REQ-017 Responses SHALL be returned in request order; no word dropped or duplicated.
REQ-018 Simultaneous push and pop at count==RESP_DEPTH SHALL NOT occur (guaranteed by REQ-014); simultaneous push and pop at other counts SHALL leave count unchanged.
REQ-019 FIFO pointers SHALL wrap modulo RESP_DEPTH; count SHALL be clog2(RESP_DEPTH+1) bits.
REQ-020 Minimum read latency: fire in cycle N -> resp_valid in cycle N+1; sustained throughput 1 read/cycle with resp_ready held 1 when RESP_DEPTH>=2.
REQ-021 Writes SHALL complete at fire and produce no response (unless REQ-026).

Reset
REQ-022 While reset_n==0: count=0, pointers=0, inflight=0; hence req_ready=1, resp_valid=0, sram_enable=0.
REQ-023 Reset asserted mid-operation SHALL discard FIFO contents and any inflight read; no response emerges after release.
REQ-024 FIFO data storage SHALL NOT be reset.

Configuration
REQ-025 Macro SRAM_REQ_ADAPTER_WRITE_ACK_EN SHALL gate write acknowledgements.
REQ-026 With it defined: a write fire SHALL set inflight and consume a credit identically to a read, producing one response with resp_data all-zero, in order with reads.
REQ-027 Without it: writes SHALL never set inflight nor produce a response.

Structure
REQ-028 Package sram_pkg SHALL hold default ADDR_WIDTH/DATA_WIDTH/MASK_UNIT constants and a mask-width helper function, shared with the SRAM.
REQ-029 Response storage SHALL be sub-module sram_resp_fifo (RESP_DEPTH x DATA_WIDTH, push/pop/count, async active-low reset).

Verification
REQ-030 Read addr 0x005 after write 0x005=0xA5..A5 mask all-ones, resp_ready=1 -> resp_valid cycle N+1, resp_data 0xA5..A5.
REQ-031 Back-to-back reads addr 0..7, resp_ready=1 -> 8 responses on consecutive cycles, in order, req_ready never drops.
REQ-032 resp_ready=0, read stream -> exactly RESP_DEPTH reads accepted, req_ready=0; raise resp_ready -> all drained in order, req_ready back to 1.
REQ-033 Write 0xFF..FF then masked write 0x00..00 mask=0x0001 -> readback low byte 0x00, others 0xFF; no write responses (macro off), one zero response per write (macro on).
REQ-034 reset_n low for 1 cycle with 2 words buffered and 1 inflight -> resp_valid=0, req_ready=1 immediately; no stale response after release.
